// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - synchronous FWFT FIFO with occupancy count, thresholds and flush
//
// Purpose: DEPTH = 2**BITS_PTR entry FIFO, head word presented combinationally
// on o_read_data (first-word-fall-through). Flags are decoded from the
// registered count. Simultaneous write+read on a full FIFO is accepted on both
// sides; on an empty FIFO only the write is accepted.
//
// Build option: FIFO_STICKY_ERR_EN
//   defined   - o_overflow / o_underflow hold until i_reset or i_clear
//   undefined - each is a one-cycle pulse after its event
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset (overrides everything)
//   i_clear        synchronous flush, memory contents kept
//   i_write        push request, i_write_data is the word
//   i_read         pop request, acknowledges o_read_data
//   o_read_data    head word, valid while o_is_empty = 0
//   o_is_empty     count == 0
//   o_is_full      count == DEPTH
//   o_almost_empty count <= ALMOST_EMPTY_TH
//   o_almost_full  count >= ALMOST_FULL_TH
//   o_count        occupancy 0..DEPTH
//   o_overflow     write rejected
//   o_underflow    read rejected
module fifo_sync_flags #(
    parameter int BITS_DATA       = 8,
    parameter int BITS_PTR        = 4,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [BITS_DATA-1:0] i_write_data,
    input  logic                 i_read,
    output logic [BITS_DATA-1:0] o_read_data,
    output logic                 o_is_empty,
    output logic                 o_is_full,
    output logic                 o_almost_empty,
    output logic                 o_almost_full,
    output logic [BITS_PTR:0]    o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int DEPTH = 2 ** BITS_PTR;
    localparam logic [BITS_PTR:0] DEPTH_C = (BITS_PTR + 1)'(DEPTH);
    localparam logic [BITS_PTR:0] AF_TH_C = (BITS_PTR + 1)'(ALMOST_FULL_TH);
    localparam logic [BITS_PTR:0] AE_TH_C = (BITS_PTR + 1)'(ALMOST_EMPTY_TH);

    logic [BITS_DATA-1:0] mem_q [DEPTH];

    logic [BITS_PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [BITS_PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [BITS_PTR:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic empty, full;
    logic wr_ok, rd_ok;
    logic ovf_evt, unf_evt;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign wr_ok   = i_write & (~full | i_read);
    assign rd_ok   = i_read & ~empty;
    assign ovf_evt = i_write & ~wr_ok;
    assign unf_evt = i_read & ~rd_ok;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (i_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + BITS_PTR'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + BITS_PTR'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + (BITS_PTR + 1)'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - (BITS_PTR + 1)'(1);
            end
`ifdef FIFO_STICKY_ERR_EN
            overflow_d  = overflow_q | ovf_evt;
            underflow_d = underflow_q | unf_evt;
`else
            overflow_d  = ovf_evt;
            underflow_d = unf_evt;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; writes are suppressed during reset and flush.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear && wr_ok) begin
            mem_q[wr_ptr_q] <= i_write_data;
        end
    end

    assign o_read_data    = mem_q[rd_ptr_q];
    assign o_is_empty     = empty;
    assign o_is_full      = full;
    assign o_almost_empty = (count_q <= AE_TH_C);
    assign o_almost_full  = (count_q >= AF_TH_C);
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - self-checking bench for fifo_sync_flags
module tb_fifo_sync_flags;

    localparam int BD    = 8;
    localparam int BP    = 4;
    localparam int DEPTH = 16;
    localparam int AF_TH = 12;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wr  = 1'b0;
    logic [BD-1:0] wd  = '0;
    logic          rd  = 1'b0;
    logic [BD-1:0] rdata;
    logic          is_empty, is_full, a_empty, a_full, ovf, unf;
    logic [BP:0]   count;

    fifo_sync_flags #(
        .BITS_DATA(BD), .BITS_PTR(BP),
        .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_clear(clr),
        .i_write(wr), .i_write_data(wd), .i_read(rd),
        .o_read_data(rdata), .o_is_empty(is_empty), .o_is_full(is_full),
        .o_almost_empty(a_empty), .o_almost_full(a_full), .o_count(count),
        .o_overflow(ovf), .o_underflow(unf)
    );

    always #5 clk = ~clk;

    // Reference: a queue of words plus the two error flags.
    logic [BD-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic w, input logic [BD-1:0] d, input logic r,
                              input logic c, input logic rs);
        bit full_now, empty_now, wok, rok;
        if (rs || c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            full_now  = (q.size() == DEPTH);
            empty_now = (q.size() == 0);
            wok = w && (!full_now || r);
            rok = r && !empty_now;
            if (rok) void'(q.pop_front());
            if (wok) q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
            m_ovf = m_ovf | (w && !wok);
            m_unf = m_unf | (r && !rok);
`else
            m_ovf = w && !wok;
            m_unf = r && !rok;
`endif
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count),    32'(n));
        chk("is_empty",     32'(is_empty), 32'(n == 0));
        chk("is_full",      32'(is_full),  32'(n == DEPTH));
        chk("almost_empty", 32'(a_empty),  32'(n <= AE_TH));
        chk("almost_full",  32'(a_full),   32'(n >= AF_TH));
        chk("overflow",     32'(ovf),      32'(m_ovf));
        chk("underflow",    32'(unf),      32'(m_unf));
        if (n > 0) chk("read_data", 32'(rdata), 32'(q[0]));
    endtask

    // One clock: apply inputs, advance model at the edge, check #1 later.
    task automatic step(input logic w, input logic [BD-1:0] d, input logic r,
                        input logic c, input logic rs);
        wr = w; wd = d; rd = r; clr = c; rst = rs;
        @(posedge clk);
        model_edge(w, d, r, c, rs);
        #1;
        check_all();
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(is_empty), 32'd1);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 0);
            if (i == AF_TH - 2) chk("af_below_th", 32'(a_full), 32'd0);
            if (i == AF_TH - 1) chk("af_at_th",    32'(a_full), 32'd1);
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_head",  32'(rdata), 32'h00);

        // Drain, checking order.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 32'(rdata), 32'(i));
            step(0, 0, 1, 0, 0);
        end
        chk("drained_empty", 32'(is_empty), 32'd1);

        // Full + write + read.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        chk("wr_rd_full_count", 32'(count), 32'd16);
        chk("wr_rd_full_head",  32'(rdata), 32'h01);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("aa_16th", 32'(rdata), 32'hAA);
            step(0, 0, 1, 0, 0);
        end

        // Empty + write + read.
        step(1, 8'h55, 1, 0, 0);
        chk("wr_rd_empty_count", 32'(count), 32'd1);
        chk("wr_rd_empty_data",  32'(rdata), 32'h55);
        chk("wr_rd_empty_unf",   32'(unf),   32'd1);
        step(0, 0, 1, 0, 0);

        // Overflow.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        step(0, 0, 0, 0, 0);
`ifdef FIFO_STICKY_ERR_EN
        chk("ovf_after", 32'(ovf), 32'd1);
`else
        chk("ovf_after", 32'(ovf), 32'd0);
`endif
        step(0, 0, 0, 1, 0);
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Count 7 then clear with a write.
        for (int i = 0; i < 7; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        step(1, 8'h99, 0, 1, 0);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_empty", 32'(is_empty), 32'd1);

        // Reset mid-burst.
        for (int i = 0; i < 5; i++) step(1, 8'(i), (i % 2) == 1, 0, 0);
        step(1, 8'h11, 1, 0, 1);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_unf",   32'(unf),   32'd0);

        // Randomised phases with varying write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
            for (int k = 0; k < 300; k++) begin
                step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                     $urandom_range(199) == 0, $urandom_range(299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised synchronous FIFO with first-word-fall-through output, occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush. Next-generation replacement for the UART RX/TX buffers and the debug-unit command/data queues. Defines simultaneous read/write at the full and empty boundaries explicitly.

Parameters:
BITS_DATA, 8, data word width
BITS_PTR, 4, address width; DEPTH = 2**BITS_PTR entries
ALMOST_FULL_TH, 12, o_almost_full asserted when count >= this value (1..DEPTH)
ALMOST_EMPTY_TH, 2, o_almost_empty asserted when count <= this value (0..DEPTH-1)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_clear  in  1  synchronous flush; empties FIFO, keeps memory contents
i_write  in  1  write request
i_write_data  in  BITS_DATA  data to push
i_read  in  1  read/pop request; acknowledges current o_read_data
o_read_data  out  BITS_DATA  head-of-queue word, valid while o_is_empty=0
o_is_empty  out  1  count == 0
o_is_full  out  1  count == DEPTH
o_almost_empty  out  1  count <= ALMOST_EMPTY_TH
o_almost_full  out  1  count >= ALMOST_FULL_TH
o_count  out  BITS_PTR+1  current occupancy, 0..DEPTH
o_overflow  out  1  write rejected (see Optional Feature)
o_underflow  out  1  read rejected (see Optional Feature)

Behaviour:
- Reset (i_reset=1, evaluated at clock edge): wr_ptr=0, rd_ptr=0, count=0; o_is_empty=1, o_is_full=0, o_almost_empty=1, o_almost_full=0 (ALMOST_FULL_TH>=1), o_count=0, o_overflow=0, o_underflow=0. Reset overrides i_clear, i_write, i_read. Memory not reset; o_read_data undefined while empty.
- i_clear=1 (no reset): same pointer/count/flag values as reset; write/read in that cycle ignored; error flags cleared.
- Storage: DEPTH x BITS_DATA array, written on the clock edge. Pointers BITS_PTR bits, wrap naturally DEPTH-1 -> 0.
- Read data: o_read_data = mem[rd_ptr], combinational (FWFT). A word written at edge N is visible on o_read_data after edge N if the FIFO was empty; write-to-read latency 1 cycle.
- Accept rules, per cycle:
  wr_ok = i_write & (~full | i_read)
  rd_ok = i_read & ~empty
- Full + write + read: both accepted; count stays DEPTH; old head popped, new word stored in the freed slot.
- Empty + write + read: write accepted, read rejected (underflow event); count becomes 1.
- Otherwise, normal case: wr_ok increments wr_ptr; rd_ok increments rd_ptr; count += wr_ok - rd_ok.
- Write while full without read: rejected, memory and pointers unchanged, overflow event.
- Read while empty: rejected, pointers unchanged, underflow event.
- Flags and thresholds are decoded combinationally from the registered count; no lag relative to o_count. Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers are equal and the FIFO is full.

Optional Feature:
FIFO_STICKY_ERR_EN
- Defined: o_overflow / o_underflow are sticky. Each sets on the edge after its event and holds until i_reset or i_clear.
- Not defined: each flag is a 1-cycle pulse registered on the edge after its event, deasserted next cycle unless the event repeats.
- Rejection behaviour is identical in both builds.

Test Plan:
- Reset, then 16 writes 0x00..0x0F with no reads -> o_count 16, o_is_full=1, o_almost_full asserts at count 12, o_read_data=0x00.
- Then 16 reads -> data 0x00..0x0F in order; o_almost_empty asserts at count 2; o_is_empty=1 after the last read; pointers wrapped to 0.
- Full FIFO, write 0xAA + read same cycle -> 0x00 popped, count stays 16, 0xAA read out 16th.
- Empty FIFO, write 0x55 + read same cycle -> count 1, o_read_data=0x55, underflow event flagged.
- Write to full FIFO (no read) -> count 16 unchanged, o_overflow=1. With FIFO_STICKY_ERR_EN it holds until i_clear; without it, it is a 1-cycle pulse.
- Count 7, assert i_clear together with i_write -> count 0, o_is_empty=1, write ignored. Then assert i_reset mid-burst -> all outputs at reset values next cycle.
